// File: rtl/mc_controller_pkg.sv
// rtl/mc_controller_pkg.sv - opcode/func constants, ALU codes, mux encodings and FSM states
package mc_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;
  localparam logic [1:0] PCSRC_REG  = 2'b11;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_R, S_WB_R, S_EX_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_WB_LW, S_MEM_WR, S_BR, S_J, S_JAL, S_JR
  } state_t;

  function automatic logic is_alu_func(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - controller <-> datapath bundle; master is the controller side
interface mc_controller_if #(parameter int CNT_W = 16);
  logic [5:0]       opcode;
  logic [5:0]       func;
  logic             zero;
  logic             mem_ready;
  logic             pc_en;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_cntrl;
  logic [1:0]       pc_src;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, func, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_cntrl, pc_src, illegal, instr_count
  );

  modport slave (
    output opcode, func, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_cntrl, pc_src, illegal, instr_count
  );
endinterface

// File: rtl/mc_controller_alu_decoder.sv
// rtl/mc_controller_alu_decoder.sv - R-type func field to ALU control code
module mc_alu_decoder
  import mc_controller_pkg::*;
(
  input  logic [5:0] i_func,
  output logic [2:0] o_alu_cntrl
);

  always_comb begin
    o_alu_cntrl = ALU_ADD;
    case (i_func)
      FN_SUB:  o_alu_cntrl = ALU_SUB;
      FN_AND:  o_alu_cntrl = ALU_AND;
      FN_OR:   o_alu_cntrl = ALU_OR;
      FN_SLT:  o_alu_cntrl = ALU_SLT;
      default: o_alu_cntrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS control FSM with memory wait, illegal detect, retire counter
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic           clk,
  input  logic           rst,
  mc_controller_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instr_count;

  logic       w_rdy, w_is_bne, w_pc_write, w_retire;
  logic       w_iord, w_mem_read, w_mem_write, w_ir_write, w_reg_write, w_alu_src_a, w_illegal;
  logic [1:0] w_reg_dst, w_mem_to_reg, w_alu_src_b, w_pc_src;
  logic [2:0] w_alu_cntrl, w_alu_r;

  assign w_rdy    = bus.mem_ready | ~MEM_WAIT_EN;
  assign w_is_bne = (bus.opcode == OP_BNE);

  mc_alu_decoder u_alu_dec (
    .i_func      (bus.func),
    .o_alu_cntrl (w_alu_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IF;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_illegal    = 1'b0;
    w_reg_dst    = REGDST_RT;
    w_mem_to_reg = M2R_ALU;
    w_alu_src_b  = SRCB_B;
    w_pc_src     = PCSRC_ALU;
    w_alu_cntrl  = ALU_AND;
    case (r_state)
      S_IF: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_4;
        w_alu_cntrl = ALU_ADD;
        w_ir_write  = w_rdy;
        w_pc_write  = w_rdy;
        if (w_rdy) w_next = S_ID;
      end
      S_ID: begin
        w_alu_src_b = SRCB_BR;
        w_alu_cntrl = ALU_ADD;
        w_next      = S_IF;
        case (bus.opcode)
          OP_RTYPE: begin
            if (bus.func == FN_JR)           w_next = S_JR;
            else if (is_alu_func(bus.func))  w_next = S_EX_R;
            else                             w_illegal = 1'b1;
          end
          OP_LW, OP_SW:     w_next = S_MEM_ADDR;
          OP_ADDI, OP_SLTI: w_next = S_EX_I;
          OP_BEQ, OP_BNE:   w_next = S_BR;
          OP_J:             w_next = S_J;
          OP_JAL:           w_next = S_JAL;
          default:          w_illegal = 1'b1;
        endcase
      end
      S_EX_R: begin
        w_alu_src_a = 1'b1;
        w_alu_cntrl = w_alu_r;
        w_next      = S_WB_R;
      end
      S_WB_R: begin
        w_reg_dst   = REGDST_RD;
        w_reg_write = 1'b1;
        w_next      = S_IF;
      end
      S_EX_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_alu_cntrl = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        w_next      = S_WB_I;
      end
      S_WB_I: begin
        w_reg_write = 1'b1;
        w_next      = S_IF;
      end
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_alu_cntrl = ALU_ADD;
        w_next      = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
        if (w_rdy) w_next = S_WB_LW;
      end
      S_WB_LW: begin
        w_mem_to_reg = M2R_MDR;
        w_reg_write  = 1'b1;
        w_next       = S_IF;
      end
      S_MEM_WR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        if (w_rdy) w_next = S_IF;
      end
      S_BR: begin
        w_alu_src_a = 1'b1;
        w_alu_cntrl = ALU_SUB;
        w_pc_src    = PCSRC_OUT;
        w_next      = S_IF;
      end
      S_J: begin
        w_pc_src   = PCSRC_JUMP;
        w_pc_write = 1'b1;
        w_next     = S_IF;
      end
      S_JAL: begin
        w_pc_src     = PCSRC_JUMP;
        w_pc_write   = 1'b1;
        w_reg_write  = 1'b1;
        w_reg_dst    = REGDST_RA;
        w_mem_to_reg = M2R_PC;
        w_next       = S_IF;
      end
      S_JR: begin
        w_pc_src   = PCSRC_REG;
        w_pc_write = 1'b1;
        w_next     = S_IF;
      end
      default: w_next = S_IF;
    endcase
  end

  // ID->IF only happens on an illegal decode, which does not retire
  assign w_retire = (r_state != S_IF) && (r_state != S_ID) && (w_next == S_IF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_instr_count <= '0;
    else if (w_retire) r_instr_count <= r_instr_count + 1'b1;
  end

  // rst gates every strobe combinationally so an aborted access stops at once
  assign bus.pc_en       = ~rst & (w_pc_write | ((r_state == S_BR) & (bus.zero ^ w_is_bne)));
  assign bus.iord        = ~rst & w_iord;
  assign bus.mem_read    = ~rst & w_mem_read;
  assign bus.mem_write   = ~rst & w_mem_write;
  assign bus.ir_write    = ~rst & w_ir_write;
  assign bus.reg_write   = ~rst & w_reg_write;
  assign bus.alu_src_a   = ~rst & w_alu_src_a;
  assign bus.illegal     = ~rst & w_illegal;
  assign bus.reg_dst     = rst ? 2'b00 : w_reg_dst;
  assign bus.mem_to_reg  = rst ? 2'b00 : w_mem_to_reg;
  assign bus.alu_src_b   = rst ? 2'b00 : w_alu_src_b;
  assign bus.pc_src      = rst ? 2'b00 : w_pc_src;
  assign bus.alu_cntrl   = rst ? 3'b000 : w_alu_cntrl;
  assign bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - instruction table with scoreboard plus reset, wait, abort and wrap sequences
module tb_mc_controller;
  import mc_controller_pkg::*;

  typedef struct {
    string      nm;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         stall;
    int         cyc;
    logic [2:0] alu;
    logic       pcen;
    logic       rw;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic [1:0] psrc;
    logic       mw;
    int         ill;
    int         dcnt;
    int         memcyc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] func = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  int         checks = 0;
  int         failures = 0;
  vec_t       vecs[$];
  vec_t       exp_q[$];

  always #5 clk = ~clk;

  mc_controller_if #(.CNT_W(16)) if1();
  mc_controller_if #(.CNT_W(4))  if2();

  assign if1.opcode = opcode;    assign if2.opcode = opcode;
  assign if1.func = func;        assign if2.func = func;
  assign if1.zero = zero;        assign if2.zero = zero;
  assign if1.mem_ready = mem_ready;
  assign if2.mem_ready = mem_ready;

  mc_controller #(.MEM_WAIT_EN(1'b1), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(if1));
  mc_controller #(.MEM_WAIT_EN(1'b0), .CNT_W(4))  dut2 (.clk(clk), .rst(rst), .bus(if2));

  localparam logic [18:0] IF_OUTS = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0,
                                     1'b0, 2'b01, 3'b010, 2'b00, 1'b0};

  function automatic logic [18:0] outs1();
    return {if1.pc_en, if1.iord, if1.mem_read, if1.mem_write, if1.ir_write, if1.reg_dst,
            if1.mem_to_reg, if1.reg_write, if1.alu_src_a, if1.alu_src_b, if1.alu_cntrl,
            if1.pc_src, if1.illegal};
  endfunction

  function automatic logic [18:0] outs2();
    return {if2.pc_en, if2.iord, if2.mem_read, if2.mem_write, if2.ir_write, if2.reg_dst,
            if2.mem_to_reg, if2.reg_write, if2.alu_src_a, if2.alu_src_b, if2.alu_cntrl,
            if2.pc_src, if2.illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, logic [5:0] op, logic [5:0] fn, logic z, int stall,
                              int cyc, logic [2:0] alu, logic pcen, logic rw, logic [1:0] rdst,
                              logic [1:0] m2r, logic [1:0] psrc, logic mw, int ill, int dcnt,
                              int memcyc);
    vec_t v;
    v.nm = nm; v.op = op; v.fn = fn; v.z = z; v.stall = stall; v.cyc = cyc; v.alu = alu;
    v.pcen = pcen; v.rw = rw; v.rdst = rdst; v.m2r = m2r; v.psrc = psrc; v.mw = mw;
    v.ill = ill; v.dcnt = dcnt; v.memcyc = memcyc;
    return v;
  endfunction

  // Starts at a falling edge with dut in IF; ends at the falling edge where IF is seen again.
  task automatic run_vec(input vec_t v);
    vec_t        o;
    vec_t        e;
    int          stalls;
    logic [15:0] c0;
    bit          done;
    bit          alu_seen;
    exp_q.push_back(v);
    opcode = v.op; func = v.fn; zero = v.z; mem_ready = 1'b1;
    stalls = v.stall;
    c0 = if1.instr_count;
    o.nm = v.nm; o.op = v.op; o.fn = v.fn; o.z = v.z; o.stall = v.stall;
    o.cyc = 1; o.alu = 3'b000; o.pcen = 1'b0; o.rw = 1'b0; o.rdst = 2'b00; o.m2r = 2'b00;
    o.psrc = 2'b00; o.mw = 1'b0; o.ill = 0; o.dcnt = 0; o.memcyc = 0;
    done = 1'b0;
    alu_seen = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (if1.mem_read && !if1.iord) begin
        done = 1'b1;
      end else begin
        o.cyc++;
        if (if1.alu_src_a && !alu_seen) begin o.alu = if1.alu_cntrl; alu_seen = 1'b1; end
        if (if1.pc_en) begin o.pcen = 1'b1; o.psrc = if1.pc_src; end
        if (if1.reg_write) begin o.rw = 1'b1; o.rdst = if1.reg_dst; o.m2r = if1.mem_to_reg; end
        if (if1.mem_write) o.mw = 1'b1;
        if (if1.illegal) o.ill++;
        if (if1.iord && (if1.mem_read || if1.mem_write)) begin
          o.memcyc++;
          if (stalls > 0) begin mem_ready = 1'b0; stalls--; end
          else mem_ready = 1'b1;
        end else begin
          mem_ready = 1'b1;
        end
      end
    end
    check({v.nm, ".done"}, {31'b0, done}, 32'd1);
    o.dcnt = int'(if1.instr_count - c0);
    e = exp_q.pop_front();
    check({e.nm, ".cyc"},    o.cyc,    e.cyc);
    check({e.nm, ".alu"},    o.alu,    e.alu);
    check({e.nm, ".pc_en"},  o.pcen,   e.pcen);
    check({e.nm, ".pc_src"}, o.psrc,   e.psrc);
    check({e.nm, ".rw"},     o.rw,     e.rw);
    check({e.nm, ".rdst"},   o.rdst,   e.rdst);
    check({e.nm, ".m2r"},    o.m2r,    e.m2r);
    check({e.nm, ".mw"},     o.mw,     e.mw);
    check({e.nm, ".ill"},    o.ill,    e.ill);
    check({e.nm, ".cnt"},    o.dcnt,   e.dcnt);
    check({e.nm, ".memcyc"}, o.memcyc, e.memcyc);
  endtask

  initial begin
    //            name       op         fn         z  stl cyc alu     pce rw rdst   m2r    psrc   mw ill cnt mem
    vecs.push_back(mk("add",   OP_RTYPE, FN_ADD,    0, 0, 4, ALU_ADD, 0, 1, 2'b01, 2'b00, 2'b00, 0, 0, 1, 0));
    vecs.push_back(mk("sub",   OP_RTYPE, FN_SUB,    0, 0, 4, ALU_SUB, 0, 1, 2'b01, 2'b00, 2'b00, 0, 0, 1, 0));
    vecs.push_back(mk("and",   OP_RTYPE, FN_AND,    0, 0, 4, ALU_AND, 0, 1, 2'b01, 2'b00, 2'b00, 0, 0, 1, 0));
    vecs.push_back(mk("or",    OP_RTYPE, FN_OR,     0, 0, 4, ALU_OR,  0, 1, 2'b01, 2'b00, 2'b00, 0, 0, 1, 0));
    vecs.push_back(mk("slt",   OP_RTYPE, FN_SLT,    0, 0, 4, ALU_SLT, 0, 1, 2'b01, 2'b00, 2'b00, 0, 0, 1, 0));
    vecs.push_back(mk("jr",    OP_RTYPE, FN_JR,     0, 0, 3, 3'b000,  1, 0, 2'b00, 2'b00, 2'b11, 0, 0, 1, 0));
    vecs.push_back(mk("lw",    OP_LW,    6'h00,     0, 0, 5, ALU_ADD, 0, 1, 2'b00, 2'b01, 2'b00, 0, 0, 1, 1));
    vecs.push_back(mk("lw_w3", OP_LW,    6'h00,     0, 3, 8, ALU_ADD, 0, 1, 2'b00, 2'b01, 2'b00, 0, 0, 1, 4));
    vecs.push_back(mk("sw",    OP_SW,    6'h00,     0, 0, 4, ALU_ADD, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 1, 1));
    vecs.push_back(mk("sw_w2", OP_SW,    6'h00,     0, 2, 6, ALU_ADD, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 1, 3));
    vecs.push_back(mk("addi",  OP_ADDI,  6'h15,     0, 0, 4, ALU_ADD, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0));
    vecs.push_back(mk("slti",  OP_SLTI,  6'h2a,     0, 0, 4, ALU_SLT, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0));
    vecs.push_back(mk("beq_t", OP_BEQ,   6'h00,     1, 0, 3, ALU_SUB, 1, 0, 2'b00, 2'b00, 2'b01, 0, 0, 1, 0));
    vecs.push_back(mk("beq_f", OP_BEQ,   6'h00,     0, 0, 3, ALU_SUB, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0));
    vecs.push_back(mk("bne_z", OP_BNE,   6'h00,     1, 0, 3, ALU_SUB, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0));
    vecs.push_back(mk("bne_n", OP_BNE,   6'h00,     0, 0, 3, ALU_SUB, 1, 0, 2'b00, 2'b00, 2'b01, 0, 0, 1, 0));
    vecs.push_back(mk("j",     OP_J,     6'h00,     0, 0, 3, 3'b000,  1, 0, 2'b00, 2'b00, 2'b10, 0, 0, 1, 0));
    vecs.push_back(mk("jal",   OP_JAL,   6'h00,     0, 0, 3, 3'b000,  1, 1, 2'b10, 2'b10, 2'b10, 0, 0, 1, 0));
    vecs.push_back(mk("ill_op", 6'h3f,   6'h00,     0, 0, 2, 3'b000,  0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0));
    vecs.push_back(mk("ill_fn", OP_RTYPE, 6'h01,    0, 0, 2, 3'b000,  0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0));

    // reset held with random inputs
    repeat (2) begin
      @(negedge clk);
      opcode = 6'($urandom); func = 6'($urandom);
      zero = 1'($urandom); mem_ready = 1'($urandom);
      #1;
      check("rst.outs1", outs1(), 0);
      check("rst.outs2", outs2(), 0);
      check("rst.cnt", if1.instr_count, 0);
    end
    @(negedge clk);
    rst = 1'b0; opcode = '0; func = '0; zero = 1'b0; mem_ready = 1'b1;
    #1;
    check("if.outs", outs1(), IF_OUTS);
    check("if.cnt", if1.instr_count, 0);
    mem_ready = 1'b0;
    #1;
    check("if.wait.ir_write", if1.ir_write, 0);
    check("if.wait.pc_en", if1.pc_en, 0);
    check("if.nowait.ir_write", if2.ir_write, 1);
    mem_ready = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset arriving while a store waits on memory
    opcode = OP_SW; func = '0; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("abort.pre.mem_write", if1.mem_write, 1);
    check("abort.pre.iord", if1.iord, 1);
    rst = 1'b1;
    #1;
    check("abort.outs", outs1(), 0);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1; opcode = '0;
    #1;
    check("abort.if.outs", outs1(), IF_OUTS);
    check("abort.cnt", if1.instr_count, 0);

    // 16 jumps with mem_ready low: no-wait dut wraps, waiting dut stays in IF
    opcode = OP_J; mem_ready = 1'b0;
    repeat (45) @(negedge clk);
    check("wrap.cnt15", if2.instr_count, 15);
    check("wrap.hold.cnt", if1.instr_count, 0);
    check("wrap.hold.mem_read", if1.mem_read, 1);
    repeat (3) @(negedge clk);
    check("wrap.cnt0", if2.instr_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
